// File: rtl/mmio_bridge_if.sv
// Bundle of the mmio_bridge request, response and MMIO bus signals.
// The bridge uses the slave view; the initiator/bus model uses the master view.
interface mmio_bridge_if;
  localparam int unsigned ADDR_W  = 23;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MADDR_W = 21;

  // Initiator request side
  logic               req_valid;
  logic               req_ready;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;

  // Completion side
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               rsp_err;
  logic               busy;

  // MMIO bus side
  logic               mmio_cs;
  logic               mmio_wr;
  logic               mmio_rd;
  logic [MADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0]  mmio_wr_data;
  logic [DATA_W-1:0]  mmio_rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mmio_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mmio_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
endinterface

// File: rtl/mmio_bridge.sv
// Request FIFO plus a four-state sequencer that turns queued read/write
// requests into single-cycle MMIO strobes and returns one in-order completion
// pulse per request. Misaligned requests complete with an error and no strobe.
module mmio_bridge #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  mmio_bridge_if.slave  bus
);

  localparam int unsigned ADDR_W  = 23;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MADDR_W = ADDR_W - 2;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  req_t               r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  // Sequencer state and holding register. The word address and write data of
  // the holding register drive the bus directly, so they only load for aligned
  // requests and therefore hold their last value across misaligned ones.
  state_t             r_state;
  logic               r_hold_wr;
  logic [MADDR_W-1:0] r_hold_waddr;
  logic [DATA_W-1:0]  r_hold_wdata;

  // Registered outputs
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_mmio_cs;
  logic               r_mmio_wr;
  logic               r_mmio_rd;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  req_t               w_in;
  req_t               w_head;
  logic               w_head_misaligned;

  assign w_full            = (r_count == CNT_W'(DEPTH));
  assign w_empty           = (r_count == '0);
  assign w_push            = bus.req_valid && !w_full;
  assign w_pop             = (r_state == IDLE) && !w_empty;
  assign w_in              = {bus.req_wr, bus.req_addr, bus.req_wdata};
  assign w_head            = r_mem[r_rptr];
  assign w_head_misaligned = (w_head.addr[1:0] != 2'b00);

  // Status decoded purely from registers, so no input-to-output path
  assign bus.req_ready    = !w_full;
  assign bus.busy         = !w_empty || (r_state != IDLE);
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.mmio_cs      = r_mmio_cs;
  assign bus.mmio_wr      = r_mmio_wr;
  assign bus.mmio_rd      = r_mmio_rd;
  assign bus.mmio_addr    = r_hold_waddr;
  assign bus.mmio_wr_data = r_hold_wdata;

  // FIFO payload write; contents are discarded by resetting the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer: strobes and completion flags are set on entry to the state in
  // which they must be visible, so each is high for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_wr    <= 1'b0;
      r_hold_waddr <= '0;
      r_hold_wdata <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_mmio_cs    <= 1'b0;
      r_mmio_wr    <= 1'b0;
      r_mmio_rd    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mmio_cs   <= 1'b0;
      r_mmio_wr   <= 1'b0;
      r_mmio_rd   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold_wr <= w_head.wr;
            if (w_head_misaligned) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state      <= ISSUE;
              r_hold_waddr <= w_head.addr[ADDR_W-1:2];
              r_hold_wdata <= w_head.wdata;
              r_mmio_cs    <= 1'b1;
              r_mmio_wr    <= w_head.wr;
              r_mmio_rd    <= !w_head.wr;
            end
          end
        end

        ISSUE: begin
          if (r_hold_wr || (RD_LAT == 0)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_hold_wr ? '0 : bus.mmio_rd_data;
          end else begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= bus.mmio_rd_data;
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: one instance with RD_LAT=0 driven from a
// vector table, one with RD_LAT=1 for read-wait and FIFO-full sequences.
module tb_mmio_bridge;

  logic clk;
  logic reset;

  mmio_bridge_if bus0 ();
  mmio_bridge_if bus1 ();

  mmio_bridge #(.DEPTH(4), .RD_LAT(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mmio_bridge #(.DEPTH(4), .RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model for RD_LAT=0: data valid only while the read strobe is high
  logic [31:0] rd_val0;
  assign bus0.mmio_rd_data = bus0.mmio_rd ? rd_val0 : 32'hDEAD_BEEF;

  // Slave model for RD_LAT=1: data valid only in the cycle after the strobe
  logic        rd_pend1;
  logic [20:0] lat_addr1;
  always @(posedge clk) begin
    if (reset) begin
      rd_pend1  <= 1'b0;
      lat_addr1 <= '0;
    end else begin
      rd_pend1  <= bus1.mmio_rd;
      lat_addr1 <= bus1.mmio_addr;
    end
  end
  assign bus1.mmio_rd_data = rd_pend1 ? (32'hC0DE_0000 ^ {11'd0, lat_addr1}) : 32'hDEAD_BEEF;

  // Observers on the RD_LAT=1 instance
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t rsp_q1[$];
  int   cs_cnt1  = 0;
  int   cs_wide1 = 0;
  int   cs_bad1  = 0;
  logic cs_prev1 = 1'b0;

  always @(negedge clk) begin
    if (bus1.rsp_valid) rsp_q1.push_back({bus1.rsp_err, bus1.rsp_rdata});
    if (bus1.mmio_cs) begin
      cs_cnt1++;
      if (cs_prev1) cs_wide1++;
      if (bus1.mmio_wr == bus1.mmio_rd) cs_bad1++;
    end else if (bus1.mmio_wr || bus1.mmio_rd) begin
      cs_bad1++;
    end
    cs_prev1 = bus1.mmio_cs;
  end

  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdval;
    int          exp_cs;
    logic [20:0] exp_maddr;
    int          exp_rsp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs  [9];
  vec_t bvecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    bus1.req_valid = 1'b1;
    bus1.req_wr    = v.wr;
    bus1.req_addr  = v.addr;
    bus1.req_wdata = v.wdata;
  endtask

  int          cs_n, rsp_n, cs_cyc, rsp_cyc;
  logic        s_wr, s_rd, s_err, s_wait_strb;
  logic [20:0] s_addr, s_raddr;
  logic [31:0] s_wd, s_rdata;
  int          k, guard, stalls, base_cs, base_wide, base_bad;
  logic        rdy;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed vectors: wr, addr, wdata, slave data, strobes, word addr, rsp cycle, err, rdata
    vecs[0] = '{1'b1, 23'h000080, 32'h0000_00A5, 32'h0,         1, 21'h00020,  2, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 23'h000180, 32'h0,         32'h1234_5678, 1, 21'h00060,  2, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 23'h000082, 32'h0000_FFFF, 32'h0,         0, 21'h00060,  1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 23'h000003, 32'h0,         32'hCAFE_F00D, 0, 21'h00060,  1, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 23'h7FFFFC, 32'h0,         32'hA5A5_5A5A, 1, 21'h1FFFFF, 2, 1'b0, 32'hA5A5_5A5A};
    vecs[5] = '{1'b1, 23'h000004, 32'hDEAD_BEEF, 32'h0,         1, 21'h000001, 2, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 23'h000000, 32'h0,         32'hFFFF_FFFF, 1, 21'h000000, 2, 1'b0, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 23'h400000, 32'h8000_0001, 32'h0,         1, 21'h100000, 2, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 23'h000001, 32'h0,         32'h55AA_55AA, 0, 21'h100000, 1, 1'b1, 32'h0};

    // Back-to-back burst on the RD_LAT=1 instance; rdata = C0DE0000 ^ word addr
    bvecs[0] = '{1'b0, 23'h000010, 32'h0,         32'h0, 1, 21'h0, 0, 1'b0, 32'hC0DE_0004};
    bvecs[1] = '{1'b1, 23'h000020, 32'h1111_1111, 32'h0, 1, 21'h0, 0, 1'b0, 32'h0};
    bvecs[2] = '{1'b0, 23'h000030, 32'h0,         32'h0, 1, 21'h0, 0, 1'b0, 32'hC0DE_000C};
    bvecs[3] = '{1'b0, 23'h000041, 32'h0,         32'h0, 0, 21'h0, 0, 1'b1, 32'h0};
    bvecs[4] = '{1'b0, 23'h7FFFF0, 32'h0,         32'h0, 1, 21'h0, 0, 1'b0, 32'hC0C1_FFFC};

    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_wr = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_wr = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    rd_val0 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst req_ready",    32'(bus0.req_ready),    32'd1);
    check("rst rsp_valid",    32'(bus0.rsp_valid),    32'd0);
    check("rst rsp_rdata",    bus0.rsp_rdata,         32'd0);
    check("rst rsp_err",      32'(bus0.rsp_err),      32'd0);
    check("rst busy",         32'(bus0.busy),         32'd0);
    check("rst strobes",      32'({bus0.mmio_cs, bus0.mmio_wr, bus0.mmio_rd}), 32'd0);
    check("rst mmio_addr",    32'(bus0.mmio_addr),    32'd0);
    check("rst mmio_wr_data", bus0.mmio_wr_data,      32'd0);
    check("rst1 busy",        32'(bus1.busy),         32'd0);
    check("rst1 req_ready",   32'(bus1.req_ready),    32'd1);

    // Table-driven single requests on the RD_LAT=0 instance
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus0.req_valid = 1'b1;
      bus0.req_wr    = vecs[i].wr;
      bus0.req_addr  = vecs[i].addr;
      bus0.req_wdata = vecs[i].wdata;
      rd_val0        = vecs[i].rdval;
      check($sformatf("v%0d req_ready", i), 32'(bus0.req_ready), 32'd1);
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      cs_n = 0; rsp_n = 0; cs_cyc = -1; rsp_cyc = -1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus0.mmio_cs) begin
          cs_n++; cs_cyc = c;
          s_wr = bus0.mmio_wr; s_rd = bus0.mmio_rd;
          s_addr = bus0.mmio_addr; s_wd = bus0.mmio_wr_data;
        end
        if (bus0.rsp_valid) begin
          rsp_n++; rsp_cyc = c;
          s_err = bus0.rsp_err; s_rdata = bus0.rsp_rdata; s_raddr = bus0.mmio_addr;
        end
      end
      check($sformatf("v%0d strobe count", i), 32'(cs_n), 32'(vecs[i].exp_cs));
      if (vecs[i].exp_cs == 1) begin
        check($sformatf("v%0d strobe cycle", i), 32'(cs_cyc), 32'd1);
        check($sformatf("v%0d mmio_wr", i), 32'(s_wr), 32'(vecs[i].wr));
        check($sformatf("v%0d mmio_rd", i), 32'(s_rd), 32'(!vecs[i].wr));
        check($sformatf("v%0d mmio_addr", i), 32'(s_addr), 32'(vecs[i].exp_maddr));
        if (vecs[i].wr) check($sformatf("v%0d mmio_wr_data", i), s_wd, vecs[i].wdata);
      end
      check($sformatf("v%0d rsp count", i), 32'(rsp_n), 32'd1);
      check($sformatf("v%0d rsp cycle", i), 32'(rsp_cyc), 32'(vecs[i].exp_rsp_cyc));
      check($sformatf("v%0d rsp_err", i), 32'(s_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d rsp_rdata", i), s_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d addr at rsp", i), 32'(s_raddr), 32'(vecs[i].exp_maddr));
      check($sformatf("v%0d busy after", i), 32'(bus0.busy), 32'd0);
    end

    // RD_LAT=1 read: data appears only in WAIT, strobe one cycle, rsp after 3
    @(posedge clk); #1;
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b0; bus1.req_addr = 23'h000100; bus1.req_wdata = '0;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    cs_n = 0; rsp_n = 0; cs_cyc = -1; rsp_cyc = -1; s_wait_strb = 1'b1; s_addr = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus1.mmio_cs) begin cs_n++; cs_cyc = c; end
      if (c == 2) begin
        s_addr = bus1.mmio_addr;
        s_wait_strb = bus1.mmio_cs | bus1.mmio_rd | bus1.mmio_wr;
      end
      if (bus1.rsp_valid) begin
        rsp_n++; rsp_cyc = c; s_err = bus1.rsp_err; s_rdata = bus1.rsp_rdata;
      end
    end
    check("lat1 strobe count", 32'(cs_n), 32'd1);
    check("lat1 strobe cycle", 32'(cs_cyc), 32'd1);
    check("lat1 wait strobes", 32'(s_wait_strb), 32'd0);
    check("lat1 wait addr", 32'(s_addr), 32'h40);
    check("lat1 rsp count", 32'(rsp_n), 32'd1);
    check("lat1 rsp cycle", 32'(rsp_cyc), 32'd3);
    check("lat1 rsp_err", 32'(s_err), 32'd0);
    check("lat1 rsp_rdata", s_rdata, 32'hC0DE_0040);

    // Five back-to-back pushes into a depth-4 FIFO
    rsp_q1.delete();
    base_cs = cs_cnt1; base_wide = cs_wide1; base_bad = cs_bad1;
    k = 0; guard = 0; stalls = 0;
    @(posedge clk); #1;
    drive1(bvecs[0]);
    while (k < 5 && guard < 60) begin
      @(negedge clk);
      rdy = bus1.req_ready;
      if (!rdy) stalls++;
      @(posedge clk); #1;
      if (rdy) k++;
      if (k < 5) drive1(bvecs[k]);
      else bus1.req_valid = 1'b0;
      guard++;
    end
    bus1.req_valid = 1'b0;
    check("b2b accepted", 32'(k), 32'd5);
    check("b2b stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    check("b2b full ready", 32'(bus1.req_ready), 32'd0);
    guard = 0;
    while (rsp_q1.size() < 5 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    check("b2b rsp count", 32'(rsp_q1.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < rsp_q1.size()) begin
        check($sformatf("b2b%0d rsp_err", j), 32'(rsp_q1[j].err), 32'(bvecs[j].exp_err));
        check($sformatf("b2b%0d rsp_rdata", j), rsp_q1[j].rdata, bvecs[j].exp_rdata);
      end
    end
    check("b2b strobes", 32'(cs_cnt1 - base_cs), 32'd4);
    check("b2b wide strobes", 32'(cs_wide1 - base_wide), 32'd0);
    check("b2b bad strobes", 32'(cs_bad1 - base_bad), 32'd0);
    check("b2b busy after", 32'(bus1.busy), 32'd0);
    check("b2b ready after", 32'(bus1.req_ready), 32'd1);

    // Reset while in ISSUE with two entries still queued
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      bus0.req_valid = 1'b1;
      bus0.req_wr    = 1'b1;
      bus0.req_addr  = 23'(32'h100 + 4 * j);
      bus0.req_wdata = 32'(j + 1);
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid busy before", 32'(bus0.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rstmid in issue", 32'(bus0.mmio_cs), 32'd1);
    check("rstmid issue addr", 32'(bus0.mmio_addr), 32'h41);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid busy", 32'(bus0.busy), 32'd0);
    check("rstmid req_ready", 32'(bus0.req_ready), 32'd1);
    check("rstmid strobes", 32'({bus0.mmio_cs, bus0.mmio_wr, bus0.mmio_rd}), 32'd0);
    check("rstmid rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    cs_n = 0; rsp_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus0.mmio_cs) cs_n++;
      if (bus0.rsp_valid) rsp_n++;
    end
    check("rstmid late strobes", 32'(cs_n), 32'd0);
    check("rstmid late rsp", 32'(rsp_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter RD_LAT, default 0: bus cycles between read strobe and mmio_rd_data sample; legal values 0 or 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator request valid.
REQ-006 SHALL have port req_ready  output  1  FIFO can accept a request.
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  23  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port rsp_err  output  1  misaligned request, valid with rsp_valid.
REQ-013 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-014 SHALL have ports mmio_cs, mmio_wr, mmio_rd  output  1 each  MMIO bus strobes.
REQ-015 SHALL have port mmio_addr  output  21  word address = req_addr[22:2].
REQ-016 SHALL have port mmio_wr_data  output  32  bus write data.
REQ-017 SHALL have port mmio_rd_data  input  32  bus read data, combinational from slots.

Function
REQ-018 SHALL push {req_wr, req_addr, req_wdata} into the FIFO on any cycle with req_valid && req_ready.
REQ-019 SHALL drive req_ready = !full; full is count == DEPTH, empty is count == 0.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-022 In IDLE with the FIFO non-empty, SHALL pop the head entry into a holding register and go to ISSUE when aligned, or to RESP with error set when req_addr[1:0] != 0.
REQ-023 In ISSUE, SHALL assert mmio_cs plus exactly one of mmio_wr or mmio_rd for exactly one cycle, with mmio_addr and mmio_wr_data taken from the holding register.
REQ-024 In ISSUE for a read with RD_LAT=0, SHALL capture mmio_rd_data at the end of that cycle and go to RESP.
REQ-025 In ISSUE for a write, SHALL always go to RESP, regardless of RD_LAT.
REQ-026 In ISSUE for a read with RD_LAT=1, SHALL go to WAIT.
REQ-027 In WAIT, SHALL hold mmio_cs/mmio_rd/mmio_wr low, hold mmio_addr stable, capture mmio_rd_data, then go to RESP.
REQ-028 In RESP, SHALL assert rsp_valid for one cycle and return to IDLE.
REQ-029 A misaligned request SHALL produce no bus strobe and SHALL complete with rsp_err=1 and rsp_rdata=0.
REQ-030 Outside ISSUE, mmio_cs, mmio_wr and mmio_rd SHALL be 0; mmio_addr and mmio_wr_data SHALL hold their last value.
REQ-031 Responses SHALL be returned in request order, exactly one per accepted request; there is no response backpressure.
REQ-032 Aligned-access latency SHALL be: FIFO-head-in-IDLE to rsp_valid = 2 cycles (RD_LAT=0 or write) or 3 cycles (RD_LAT=1 read).

Reset
REQ-033 On reset, SHALL set FSM=IDLE, FIFO count and pointers=0, and holding register=0.
REQ-034 On reset, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, mmio_cs/wr/rd=0, mmio_addr=0, mmio_wr_data=0.
REQ-035 Reset mid-transaction SHALL abort it: any pending response is dropped, FIFO contents are discarded, and no strobe is asserted in the cycle after reset.

Verification
REQ-036 Write 0x0000_00A5 to byte addr 0x000080 -> one ISSUE cycle with mmio_cs=1, mmio_wr=1, mmio_addr=0x00020, mmio_wr_data=0xA5; next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-037 Read at 0x000180 while the bench returns mmio_rd_data=0x1234_5678 in the ISSUE cycle (RD_LAT=0) -> mmio_addr=0x00060, mmio_rd=1; rsp_rdata=0x1234_5678 two cycles after IDLE pop.
REQ-038 RD_LAT=1, bench drives read data only in WAIT -> that value returned, and the strobe is 1 cycle wide.
REQ-039 Push 5 back-to-back requests with DEPTH=4 -> req_ready drops after the 4th unpopped push; all 5 complete in order with 5 rsp_valid pulses.
REQ-040 Request at addr 0x000082 -> no mmio_cs assertion; rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
REQ-041 Assert reset during ISSUE with 2 entries queued -> no rsp_valid afterwards; busy=0 and req_ready=1 the following cycle.
